// File: rtl/agn_burst_if.sv
// Handshake/bus bundle between the sequencer/generator side and agn_burst_ctrl.
// The stop line exists only when AGN_BURST_STOP_EN is defined.
interface agn_burst_if;
    logic       start;
    logic [7:0] m_peak;
    logic [7:0] m_step;
    logic [7:0] n_hold;
    logic       co_sin;
`ifdef AGN_BURST_STOP_EN
    logic       stop;
`endif
    logic       ce_gen;
    logic [7:0] m_out;
    logic       busy;
    logic       done;

    modport master (
`ifdef AGN_BURST_STOP_EN
        output stop,
`endif
        output start, m_peak, m_step, n_hold, co_sin,
        input  ce_gen, m_out, busy, done
    );

    modport slave (
`ifdef AGN_BURST_STOP_EN
        input  stop,
`endif
        input  start, m_peak, m_step, n_hold, co_sin,
        output ce_gen, m_out, busy, done
    );
endinterface

// File: rtl/agn_burst_ctrl.sv
// Burst/envelope controller for the AM sine generator: divided clock-enable plus an
// up/hold/down ramp of M stepped on CO_SIN. Define AGN_BURST_STOP_EN to enable abort.
module agn_burst_ctrl #(
    parameter int unsigned CE_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    agn_burst_if.slave bus
);
    localparam int DW = $clog2(CE_DIV);

    typedef enum logic [2:0] {S_IDLE, S_UP, S_HOLD, S_DOWN, S_FIN} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [7:0]    peak_q;
    logic [7:0]    step_q;
    logic [7:0]    hold_q;
    logic [7:0]    hold_cnt;
    logic [8:0]    up_sum;
    logic [8:0]    dn_diff;
    logic          run;
    logic          stop_req;

`ifdef AGN_BURST_STOP_EN
    assign stop_req = bus.stop;
`else
    assign stop_req = 1'b0;
`endif

    assign run     = (state == S_UP) || (state == S_HOLD) || (state == S_DOWN);
    assign div_nxt = (div_cnt == DW'(CE_DIV - 1)) ? '0 : div_cnt + 1'b1;
    // 9-bit arithmetic: carry marks overshoot past 255, borrow marks undershoot below 0
    assign up_sum  = {1'b0, bus.m_out} + {1'b0, step_q};
    assign dn_diff = {1'b0, bus.m_out} - {1'b0, step_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bus.ce_gen <= 1'b0;
            bus.m_out  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            peak_q     <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            hold_cnt   <= '0;
        end else begin
            bus.done <= 1'b0;
            // ce_gen is high during the cycle in which the divider sits at CE_DIV-1
            if (run) begin
                div_cnt    <= div_nxt;
                bus.ce_gen <= (div_nxt == DW'(CE_DIV - 1));
            end else begin
                div_cnt    <= '0;
                bus.ce_gen <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        peak_q    <= bus.m_peak;
                        step_q    <= (bus.m_step == 8'd0) ? 8'd1 : bus.m_step;
                        hold_q    <= bus.n_hold;
                        bus.m_out <= '0;
                        div_cnt   <= '0;
                        if (bus.m_peak == 8'd0) begin
                            state    <= S_FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= S_UP;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                S_UP: begin
                    if (stop_req) begin
                        state <= S_DOWN;
                    end else if (bus.co_sin) begin
                        if (up_sum >= {1'b0, peak_q}) begin
                            bus.m_out <= peak_q;
                            if (hold_q == 8'd0) begin
                                state <= S_DOWN;
                            end else begin
                                state    <= S_HOLD;
                                hold_cnt <= hold_q;
                            end
                        end else begin
                            bus.m_out <= up_sum[7:0];
                        end
                    end
                end
                S_HOLD: begin
                    if (stop_req) begin
                        state <= S_DOWN;
                    end else if (bus.co_sin) begin
                        hold_cnt <= hold_cnt - 8'd1;
                        if (hold_cnt == 8'd1)
                            state <= S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (bus.co_sin) begin
                        if (dn_diff[8] || (dn_diff == 9'd0)) begin
                            bus.m_out  <= '0;
                            state      <= S_FIN;
                            bus.busy   <= 1'b0;
                            bus.done   <= 1'b1;
                            bus.ce_gen <= 1'b0;
                            div_cnt    <= '0;
                        end else begin
                            bus.m_out <= dn_diff[7:0];
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_agn_burst_ctrl.sv
// Self-checking bench for agn_burst_ctrl: directed profiles plus random bursts,
// checked against an M-sequence list built from the ramp rules.
module tb_agn_burst_ctrl;
    localparam int CE_DIV = 4;
    localparam int P      = 3;  // generator samples per sine period

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;

    agn_burst_if bus();

    agn_burst_ctrl #(.CE_DIV(CE_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator stand-in: period counter advanced by ce_gen, never reset by rst_n
    always @(posedge clk)
        if (bus.ce_gen === 1'b1)
            phase <= (phase == P - 1) ? 0 : phase + 1;
    assign bus.co_sin = (bus.ce_gen === 1'b1) && (phase == P - 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_burst(input int pk, input int st, input int hd, input bit keep_start,
                             input bit poke, input int stop_at, input bit stop_co, input int rst_at);
        int q[$];
        int m, s, cyc, last_ce, budget, pops;
        bit co, stopped;
        s = (st == 0) ? 1 : st;
        m = 0;
        if (pk != 0) begin
            while (m < pk) begin
                m = (m + s > pk) ? pk : m + s;
                q.push_back(m);
            end
            repeat (hd) q.push_back(pk);
            while (m > 0) begin
                m = (m > s) ? m - s : 0;
                q.push_back(m);
            end
        end
        if (stop_at > 0) begin
            while (q.size() > stop_at) void'(q.pop_back());
            m = q[$];
            if (stop_co) q.push_back(m);
            while (m > 0) begin
                m = (m > s) ? m - s : 0;
                q.push_back(m);
            end
        end

        bus.m_peak = pk[7:0];
        bus.m_step = st[7:0];
        bus.n_hold = hd[7:0];
        bus.start  = 1'b1;
        tick();
        if (!keep_start) bus.start = 1'b0;

        if (pk == 0) begin
            chk("zero_done", bus.done, 1);
            chk("zero_busy", bus.busy, 0);
            chk("zero_ce", bus.ce_gen, 0);
            tick();
            chk("zero_done_end", bus.done, 0);
            chk("zero_busy_end", bus.busy, 0);
            chk("zero_ce_end", bus.ce_gen, 0);
            return;
        end

        chk("start_busy", bus.busy, 1);
        chk("start_m", bus.m_out, 0);
        chk("start_done", bus.done, 0);
        cyc = 0; last_ce = -1; pops = 0; stopped = 0;
        budget = (q.size() + 2) * P * CE_DIV + 4 * CE_DIV;
        while (q.size() > 0 && budget > 0) begin
`ifdef AGN_BURST_STOP_EN
            if (stop_at > 0 && !stopped && pops == stop_at && (!stop_co || bus.co_sin)) begin
                bus.stop = 1'b1;
                stopped  = 1'b1;
            end
`endif
            co = bus.co_sin;
            tick();
            cyc++;
            budget--;
`ifdef AGN_BURST_STOP_EN
            bus.stop = 1'b0;
`endif
            if (poke && cyc == 6) begin
                bus.start  = 1'b1;
                bus.m_peak = 8'($urandom);
                bus.m_step = 8'($urandom);
                bus.n_hold = 8'($urandom);
            end
            if (poke && cyc == 7) bus.start = 1'b0;
            if (bus.ce_gen === 1'b1) begin
                if (last_ce < 0) chk("first_ce", cyc, CE_DIV - 1);
                else             chk("ce_period", cyc - last_ce, CE_DIV);
                last_ce = cyc;
            end
            if (co) begin
                chk("m_step", bus.m_out, q.pop_front());
                pops++;
            end
            if (q.size() > 0) begin
                chk("busy_run", bus.busy, 1);
                chk("done_run", bus.done, 0);
            end
            if (rst_at > 0 && pops == rst_at) begin
                tick();
                rst_n     = 1'b0;
                bus.start = 1'b1;
                tick();
                rst_n     = 1'b1;
                bus.start = 1'b0;
                chk("rst_m", bus.m_out, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_ce", bus.ce_gen, 0);
                chk("rst_done", bus.done, 0);
                repeat (P * CE_DIV * 2) begin
                    tick();
                    chk("rst_no_done", bus.done, 0);
                    chk("rst_no_ce", bus.ce_gen, 0);
                end
                return;
            end
        end
        if (q.size() > 0) begin
            chk("timeout_co_sin", q.size(), 0);
            return;
        end
        chk("fin_done", bus.done, 1);
        chk("fin_busy", bus.busy, 0);
        chk("fin_ce", bus.ce_gen, 0);
        chk("fin_m", bus.m_out, 0);
        tick();
        chk("idle_done", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_ce", bus.ce_gen, 0);
    endtask

    initial begin
        int pk, st, hd;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.m_peak = '0;
        bus.m_step = '0;
        bus.n_hold = '0;
`ifdef AGN_BURST_STOP_EN
        bus.stop   = 1'b0;
`endif
        tick();
        tick();
        chk("reset_m", bus.m_out, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_ce", bus.ce_gen, 0);
        rst_n = 1'b1;
        tick();

        run_burst(128, 32, 2, 0, 0, -1, 0, -1);   // full profile
        run_burst(100, 40, 0, 0, 0, -1, 0, -1);   // saturation, direct UP->DOWN
        run_burst(0, 17, 3, 0, 0, -1, 0, -1);     // peak 0
        run_burst(3, 0, 0, 0, 0, -1, 0, -1);      // step 0 treated as 1
        run_burst(255, 255, 1, 0, 0, -1, 0, -1);  // single-step extremes
        run_burst(128, 32, 2, 0, 1, -1, 0, -1);   // second start while busy
        run_burst(60, 20, 1, 1, 0, -1, 0, -1);    // start held through FIN
        run_burst(50, 25, 0, 0, 0, -1, 0, -1);
        run_burst(128, 32, 2, 0, 0, -1, 0, 4);    // reset mid-HOLD
        run_burst(128, 32, 2, 0, 0, -1, 0, -1);
`ifdef AGN_BURST_STOP_EN
        run_burst(128, 32, 2, 0, 0, 2, 0, -1);    // stop at m_out=64
        run_burst(128, 32, 2, 0, 0, 2, 1, -1);    // stop coincident with co_sin
`endif
        for (int i = 0; i < 12; i++) begin
            pk = $urandom_range(0, 255);
            st = $urandom_range(1, 255);
            hd = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) begin
                st = 0;
                pk = $urandom_range(0, 10);
            end
            run_burst(pk, st, hd, 0, 0, -1, 0, -1);
            repeat ($urandom_range(0, 5)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
